// File: rtl/sseg_decoder.sv
// Recovers hex digits from a multiplexed, active-low 7-segment bus and tracks in-order 0..5 frames.
// Optional build macro SSEG_DECODER_LATCH_EN: DIGITS updates atomically on frame completion only.
module sseg_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [5:0]  SEL_IN,
    input  logic [6:0]  HEX_IN,
    input  logic        CLEAR,
    output logic [23:0] DIGITS,
    output logic [5:0]  DIG_VALID,
    output logic        FRAME_DONE,
    output logic [7:0]  FRAME_CNT,
    output logic        ERR
);

    localparam logic [8:0] STABLE_W = 9'(STABLE_CYCLES);

    typedef enum logic [0:0] {HUNT = 1'b0, COLLECT = 1'b1} state_e;

    // Returns {valid, nibble} for an active-low {g..a} segment pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [12:0] sync1_q, sync2_q, prev_q;
    logic [7:0]  stab_q, stab_d;
    logic        changed_s, capture_s;
    logic [5:0]  sel_lo_s;
    logic        blank_s, multi_s, cap_ok_s, valid_cap_s, err_cap_s;
    logic [4:0]  dec_s;
    logic [2:0]  idx_s;
    logic [23:0] written_s;

    state_e      state_q;
    logic [2:0]  exp_q;
    logic [23:0] digits_q;
    logic [5:0]  valid_q;
    logic        done_q;
    logic [7:0]  cnt_q;
    logic        err_q;
`ifdef SSEG_DECODER_LATCH_EN
    logic [23:0] shadow_q;
`endif

    // Stability window: held = 1 on the first differing cycle, cnt+2 afterwards.
    always_comb begin
        stab_d    = stab_q;
        capture_s = 1'b0;
        changed_s = (sync2_q != prev_q);
        if (changed_s) begin
            stab_d    = 8'd0;
            capture_s = (STABLE_W == 9'd1);
        end else begin
            if (stab_q == 8'hFF) begin
                stab_d = stab_q;
            end else begin
                stab_d = stab_q + 8'd1;
            end
            capture_s = (({1'b0, stab_q} + 9'd2) == STABLE_W);
        end
    end

    // Classify the captured pair and build the updated digit word.
    always_comb begin
        sel_lo_s = ~sync2_q[12:7];
        blank_s  = (sel_lo_s == 6'd0);
        multi_s  = ((sel_lo_s & (sel_lo_s - 6'd1)) != 6'd0);
        dec_s    = hex_decode(sync2_q[6:0]);
        case (sel_lo_s)
            6'b000001: idx_s = 3'd0;
            6'b000010: idx_s = 3'd1;
            6'b000100: idx_s = 3'd2;
            6'b001000: idx_s = 3'd3;
            6'b010000: idx_s = 3'd4;
            6'b100000: idx_s = 3'd5;
            default:   idx_s = 3'd0;
        endcase
        cap_ok_s    = capture_s & ~CLEAR & ~blank_s;
        err_cap_s   = cap_ok_s & (multi_s | ~dec_s[4]);
        valid_cap_s = cap_ok_s & ~multi_s & dec_s[4];
`ifdef SSEG_DECODER_LATCH_EN
        written_s = shadow_q;
`else
        written_s = digits_q;
`endif
        written_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
    end

    // Synchronizers, stability counter, digit storage and frame FSM.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q  <= 13'h1FFF;
            sync2_q  <= 13'h1FFF;
            prev_q   <= 13'h1FFF;
            stab_q   <= 8'd0;
            state_q  <= HUNT;
            exp_q    <= 3'd1;
            digits_q <= 24'd0;
            valid_q  <= 6'd0;
            done_q   <= 1'b0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
`ifdef SSEG_DECODER_LATCH_EN
            shadow_q <= 24'd0;
`endif
        end else begin
            sync1_q <= {SEL_IN, HEX_IN};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
            done_q  <= 1'b0;
            if (CLEAR) begin
                valid_q <= 6'd0;
                err_q   <= 1'b0;
                cnt_q   <= 8'd0;
                state_q <= HUNT;
                exp_q   <= 3'd1;
            end else if (err_cap_s) begin
                err_q   <= 1'b1;
                state_q <= HUNT;
            end else if (valid_cap_s) begin
                valid_q[idx_s] <= 1'b1;
`ifdef SSEG_DECODER_LATCH_EN
                shadow_q <= written_s;
`else
                digits_q <= written_s;
`endif
                if (idx_s == 3'd0) begin
                    state_q <= COLLECT;
                    exp_q   <= 3'd1;
                end else if (state_q == COLLECT) begin
                    if (idx_s == exp_q) begin
                        if (idx_s == 3'd5) begin
                            done_q  <= 1'b1;
                            cnt_q   <= cnt_q + 8'd1;
                            state_q <= HUNT;
`ifdef SSEG_DECODER_LATCH_EN
                            digits_q <= written_s;
`endif
                        end else begin
                            exp_q <= exp_q + 3'd1;
                        end
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= HUNT;
                    end
                end else begin
                    state_q <= HUNT;
                end
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign DIGITS     = digits_q;
    assign DIG_VALID  = valid_q;
    assign FRAME_DONE = done_q;
    assign FRAME_CNT  = cnt_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_sseg_decoder.sv
// Scoreboard bench for sseg_decoder: a reference model predicts each capture and its edge.
module tb_sseg_decoder;

    localparam int NST = 4;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [5:0]  SEL_IN = 6'h3F;
    logic [6:0]  HEX_IN = 7'h7F;
    logic        CLEAR = 1'b0;
    logic [23:0] DIGITS;
    logic [5:0]  DIG_VALID;
    logic        FRAME_DONE;
    logic [7:0]  FRAME_CNT;
    logic        ERR;

    sseg_decoder #(.STABLE_CYCLES(NST)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SEL_IN(SEL_IN), .HEX_IN(HEX_IN),
        .CLEAR(CLEAR), .DIGITS(DIGITS), .DIG_VALID(DIG_VALID),
        .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT), .ERR(ERR)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int          cap_edge;
        logic [23:0] pre_dig;
        logic [5:0]  pre_val;
        logic [23:0] dig;
        logic [5:0]  val;
        logic        err;
        logic [7:0]  cnt;
        logic        done;
    } rec_t;

    rec_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_seen = 0;
    int   done_total = 0;

    logic [6:0]  pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [23:0] m_dig = 24'd0;
    logic [23:0] m_shadow = 24'd0;
    logic [5:0]  m_val = 6'd0;
    logic        m_err = 1'b0;
    logic [7:0]  m_cnt = 8'd0;
    logic        m_done = 1'b0;
    logic        m_hunt = 1'b1;
    int          m_exp = 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_cap(input logic [5:0] sel, input logic [6:0] hex);
        int zeros, nib, idx;
        zeros  = $countones(~sel);
        nib    = -1;
        idx    = 0;
        m_done = 1'b0;
        for (int i = 0; i < 16; i++) if (pats[i] == hex) nib = i;
        for (int i = 0; i < 6; i++) if (!sel[i]) idx = i;
        if (zeros == 0) return;
        if (zeros > 1 || nib < 0) begin
            m_err = 1'b1; m_hunt = 1'b1;
            return;
        end
`ifdef SSEG_DECODER_LATCH_EN
        m_shadow[idx*4 +: 4] = 4'(nib);
`else
        m_dig[idx*4 +: 4] = 4'(nib);
`endif
        m_val[idx] = 1'b1;
        if (idx == 0) begin
            m_hunt = 1'b0; m_exp = 1;
        end else if (!m_hunt) begin
            if (idx == m_exp) begin
                if (idx == 5) begin
                    m_done = 1'b1; m_cnt++; done_total++; m_hunt = 1'b1;
`ifdef SSEG_DECODER_LATCH_EN
                    m_dig = m_shadow;
`endif
                end else begin
                    m_exp++;
                end
            end else begin
                m_err = 1'b1; m_hunt = 1'b1;
            end
        end
    endtask

    task automatic model_clear();
        m_val = 6'd0; m_err = 1'b0; m_cnt = 8'd0; m_hunt = 1'b1; m_exp = 1;
    endtask

    task automatic apply(input logic [5:0] sel, input logic [6:0] hex, input int hold);
        rec_t r;
        @(negedge CLOCK);
        SEL_IN = sel;
        HEX_IN = hex;
        if (hold >= NST) begin
            r.pre_dig = m_dig;
            r.pre_val = m_val;
            model_cap(sel, hex);
            r.dig = m_dig; r.val = m_val; r.err = m_err; r.cnt = m_cnt; r.done = m_done;
            r.cap_edge = cyc + NST + 2;
            sb.push_back(r);
        end
        repeat (hold - 1) @(negedge CLOCK);
    endtask

    task automatic sweep(input int first, input int last, input int hold);
        logic [5:0] s;
        for (int i = first; i <= last; i++) begin
            s = ~(6'd1 << i);
            apply(s, pats[i], hold);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLOCK);
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic do_clear();
        drain();
        @(negedge CLOCK);
        CLEAR = 1'b1;
        @(negedge CLOCK);
        CLEAR = 1'b0;
        model_clear();
        check_eq("clr_err", ERR, 1'b0);
        check_eq("clr_valid", DIG_VALID, 6'd0);
        check_eq("clr_cnt", FRAME_CNT, 8'd0);
        check_eq("clr_digits", DIGITS, m_dig);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_digits"}, DIGITS, 24'd0);
        check_eq({tag, "_valid"}, DIG_VALID, 6'd0);
        check_eq({tag, "_done"}, FRAME_DONE, 1'b0);
        check_eq({tag, "_cnt"}, FRAME_CNT, 8'd0);
        check_eq({tag, "_err"}, ERR, 1'b0);
    endtask

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Scoreboard monitor: state unchanged one cycle before each capture, exact after it.
    always @(negedge CLOCK) begin
        rec_t r;
        if (FRAME_DONE === 1'b1) done_seen <= done_seen + 1;
        if (sb.size() > 0) begin
            if (cyc == sb[0].cap_edge - 1) begin
                check_eq("pre_digits", DIGITS, sb[0].pre_dig);
                check_eq("pre_valid", DIG_VALID, sb[0].pre_val);
            end else if (cyc >= sb[0].cap_edge) begin
                r = sb.pop_front();
                check_eq("cap_cycle", cyc, r.cap_edge);
                check_eq("digits", DIGITS, r.dig);
                check_eq("dig_valid", DIG_VALID, r.val);
                check_eq("err", ERR, r.err);
                check_eq("frame_cnt", FRAME_CNT, r.cnt);
                check_eq("frame_done", FRAME_DONE, r.done);
            end
        end
    end

    initial begin
        #1 RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK);
        check_all_zero("reset");
        RESET_N = 1'b1;

        // Full ordered frame, generous hold.
        sweep(0, 5, 10);
        drain();
        check_eq("sweep_digits", DIGITS, 24'h543210);
        check_eq("sweep_cnt", FRAME_CNT, 8'd1);
        check_eq("sweep_err", ERR, 1'b0);
        repeat (2) @(negedge CLOCK);
        check_eq("sweep_pulses", done_seen, 1);

        // Stability boundary: N-1 clocks ignored, exactly N clocks captured.
        apply(6'h3E, 7'h00, NST - 1);
        apply(6'h3E, 7'h78, NST);
        apply(6'h3D, 7'h24, NST + 3);
        drain();

        // Two digits selected at once, then clear.
        apply(6'h3C, 7'h40, 10);
        drain();
        check_eq("multi_err", ERR, 1'b1);
        do_clear();

        // Out-of-order frame, then a good one.
        sweep(0, 1, 6);
        apply(6'h37, pats[3], 6);
        sweep(0, 5, 6);
        drain();
        check_eq("order_cnt", FRAME_CNT, 8'd1);

        // Blank and undecodable patterns.
        apply(6'h3F, 7'h40, 8);
        apply(6'h3E, 7'h7F, 8);
        drain();
        check_eq("badhex_err", ERR, 1'b1);
        do_clear();

        // Counter wrap after 256 frames at minimum hold.
        for (int f = 0; f < 256; f++) sweep(0, 5, NST);
        drain();
        check_eq("wrap_cnt", FRAME_CNT, 8'd0);

        // Reset in the middle of a frame with everything non-zero.
        sweep(0, 5, NST);
        apply(6'h3C, 7'h40, 8);
        sweep(0, 2, 8);
        drain();
        @(negedge CLOCK);
        #2 RESET_N = 1'b0;
        SEL_IN = 6'h3F;
        HEX_IN = 7'h7F;
        #1 check_all_zero("midreset");
        m_dig = 24'd0; m_shadow = 24'd0;
        model_clear();
        @(negedge CLOCK);
        RESET_N = 1'b1;
        sweep(0, 5, 7);
        drain();
        check_eq("post_reset_cnt", FRAME_CNT, 8'd1);
        check_eq("post_reset_digits", DIGITS, 24'h543210);

        repeat (2) @(negedge CLOCK);
        check_eq("total_pulses", done_seen, done_total);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sseg_decoder.md
SSEG_DECODER -- requirements
Module: sseg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal 1..255): consecutive clocks a synchronized {SEL_IN,HEX_IN} pair must hold before capture.
REQ-002 SHALL have port CLOCK  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port SEL_IN  input  6  multiplexed digit select, active-low; bit i low selects digit i.
REQ-005 SHALL have port HEX_IN  input  7  segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
REQ-006 SHALL have port CLEAR  input  1  synchronous clear of captured state.
REQ-007 SHALL have port DIGITS  output  24  decoded nibbles; digit i at [4i+3:4i].
REQ-008 SHALL have port DIG_VALID  output  6  bit i set once digit i has been captured since reset/CLEAR.
REQ-009 SHALL have port FRAME_DONE  output  1  one-cycle pulse on completion of an in-order 0..5 frame.
REQ-010 SHALL have port FRAME_CNT  output  8  completed-frame count, wraps 255->0.
REQ-011 SHALL have port ERR  output  1  sticky error flag.

Function
REQ-012 SHALL pass SEL_IN and HEX_IN through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep a saturating stability counter, zeroed whenever the synchronized pair differs from its previous-cycle value.
REQ-014 SHALL issue exactly one capture event per stable window: the edge on which the pair has been stable STABLE_CYCLES clocks, i.e. STABLE_CYCLES+2 edges after the first edge sampling the new input.
REQ-015 SHALL ignore capture events with SEL = 6'h3F (blanking); no state change.
REQ-016 SHALL treat capture with more than one SEL bit low as error: set ERR, state -> HUNT, no digit write.
REQ-017 SHALL decode HEX (hex of 7-bit pattern) 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E; any other pattern sets ERR, no digit write, state -> HUNT.
REQ-018 SHALL, on valid capture of digit i, write its nibble to digit i storage and set DIG_VALID[i].
REQ-019 SHALL run frame FSM with states HUNT and COLLECT(expected index 1..5).
REQ-020 SHALL, on valid capture of digit 0 in any state, enter COLLECT with expected=1 (no error).
REQ-021 SHALL, in COLLECT, on valid capture of expected index, advance expected; on index 5 assert FRAME_DONE next edge for one cycle, increment FRAME_CNT, return to HUNT.
REQ-022 SHALL, in COLLECT, on valid capture of any non-zero index other than expected (including a repeat), set ERR and return to HUNT; digit still written.
REQ-023 SHALL, in HUNT, write non-zero digits without frame progress or error.
REQ-024 SHALL on CLEAR: DIG_VALID=0, ERR=0, FRAME_CNT=0, FRAME_DONE=0, state HUNT; a capture coincident with CLEAR is discarded; DIGITS unchanged.

Reset
REQ-025 SHALL asynchronously on RESET_N low set DIGITS=0, DIG_VALID=0, FRAME_DONE=0, FRAME_CNT=0, ERR=0, synchronizers=7F/3F (all high), stability counter=0, state HUNT.
REQ-026 SHALL resume capture only via a fresh stable window after RESET_N rises; reset mid-frame discards partial frame.

Configuration
REQ-027 SHALL honour macro SSEG_DECODER_LATCH_EN: defined -> captures go to a shadow register and DIGITS loads all 24 bits atomically on the FRAME_DONE edge only; undefined -> DIGITS updates per capture (REQ-018). DIG_VALID behaves identically either way.

Verification
REQ-028 SHALL cover: drive SEL 3E/3D/3B/37/2F/1F with patterns 40,79,24,30,19,12 each held 10 clocks -> DIGITS=24'h543210, one FRAME_DONE, FRAME_CNT=1, ERR=0.
REQ-029 SHALL cover: pair held exactly STABLE_CYCLES-1 clocks then changed -> no capture; held STABLE_CYCLES -> capture at edge STABLE_CYCLES+2.
REQ-030 SHALL cover: SEL=3C with HEX=40 stable -> ERR=1, DIGITS unchanged; then CLEAR -> ERR=0, DIG_VALID=0.
REQ-031 SHALL cover: digit order 0,1,3 -> ERR=1 on digit 3, no FRAME_DONE; next full 0..5 sweep -> FRAME_DONE, FRAME_CNT=1.
REQ-032 SHALL cover: 256 complete frames -> FRAME_CNT wraps to 0; RESET_N low mid-frame -> all outputs zero immediately.
REQ-033 SHALL cover with SSEG_DECODER_LATCH_EN: DIGITS holds prior frame value until FRAME_DONE edge, then shows new 24-bit value.
